key_schedule_ctrl: RTL and testbench

- Sequences the 128-bit key-schedule datapath: loads a cipher key, steps the round counter 0..NUM_ROUNDS one round per clock, and captures each round key into an internal round-key store.
- Exposes a registered random-access read port to the cipher round core.
- Sits between the key-load interface and the key-schedule datapath instance; the datapath itself stays purely combinational.

---
 rtl/key_schedule_ctrl.sv | 141 ++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Round-key schedule sequencer with a registered random-access round-key store.
// Optional macro KEY_SCHED_REVERSE_EN adds rk_reverse for decryption-order reads.
module key_schedule_ctrl #(
   parameter int NUM_ROUNDS = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic         key_clear,
   output logic         busy,
   output logic         rk_ready,
   output logic [127:0] ks_data_in,
   output logic [3:0]   ks_round,
   input  logic [127:0] ks_data_out,
   input  logic [3:0]   rk_rd_idx,
`ifdef KEY_SCHED_REVERSE_EN
   input  logic         rk_reverse,
`endif
   output logic [127:0] rk_rd_data
);

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]   state_r;
   logic [127:0] w_r;
   logic [3:0]   r_r;
   logic         key_ready_r;
   logic         busy_r;
   logic         rk_ready_r;
   logic [127:0] rd_data_r;
   logic [127:0] store_r [0:NUM_ROUNDS];

   logic         rd_ok_s;
   logic [3:0]   eff_idx_s;
   logic         store_we_s;

   assign ks_data_in = w_r;
   assign ks_round   = r_r;
   assign key_ready  = key_ready_r;
   assign busy       = busy_r;
   assign rk_ready   = rk_ready_r;
   assign rk_rd_data = rd_data_r;

   // Range check is done on the raw index, before any reverse mapping.
   always_comb begin
      rd_ok_s   = (rk_rd_idx <= LAST);
      eff_idx_s = rk_rd_idx;
`ifdef KEY_SCHED_REVERSE_EN
      if (rk_reverse) begin
         eff_idx_s = LAST - rk_rd_idx;
      end else begin
         eff_idx_s = rk_rd_idx;
      end
`endif
      store_we_s = (state_r == RUN) && !key_clear;
   end

   // Control FSM: working register, round counter and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         w_r         <= 128'd0;
         r_r         <= 4'd0;
         key_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         rk_ready_r  <= 1'b0;
      end else if (key_clear) begin
         state_r     <= IDLE;
         w_r         <= 128'd0;
         r_r         <= 4'd0;
         key_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         rk_ready_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (key_valid) begin
                  state_r     <= RUN;
                  w_r         <= key_in;
                  r_r         <= 4'd0;
                  key_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  rk_ready_r  <= 1'b0;
               end
            end
            RUN: begin
               // Round 0 stores the key itself; W only advances from round 1 on.
               if (r_r != 4'd0) begin
                  w_r <= ks_data_out;
               end
               if (r_r == LAST) begin
                  state_r     <= DONE;
                  r_r         <= 4'd0;
                  key_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
                  rk_ready_r  <= 1'b1;
               end else begin
                  r_r <= r_r + 4'd1;
               end
            end
            default: begin
               state_r     <= IDLE;
               w_r         <= 128'd0;
               r_r         <= 4'd0;
               key_ready_r <= 1'b1;
               busy_r      <= 1'b0;
               rk_ready_r  <= 1'b0;
            end
         endcase
      end
   end

   // Round-key store capture; a clear retains contents and blocks the pending write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            store_r[i] <= 128'd0;
         end
      end else if (store_we_s) begin
         store_r[r_r] <= ks_data_out;
      end
   end

   // Registered read port; same-cycle write to the same index returns the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r <= 128'd0;
      end else if (rd_ok_s) begin
         rd_data_r <= store_r[eff_idx_s];
      end else begin
         rd_data_r <= 128'd0;
      end
   end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed, table-driven bench for key_schedule_ctrl with a behavioural datapath model.
module tb_key_schedule_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         key_clear;
   logic         busy;
   logic         rk_ready;
   logic [127:0] ks_data_in;
   logic [3:0]   ks_round;
   logic [127:0] ks_data_out;
   logic [3:0]   rk_rd_idx;
   logic [127:0] rk_rd_data;
`ifdef KEY_SCHED_REVERSE_EN
   logic         rk_reverse;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] exp;
   } rd_vec_t;

   rd_vec_t      tbl [15];
   logic [127:0] gold [0:2][0:12];

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_C = 128'hdeadbeef0123456789abcdeffedcba98;

   always #5 clk = ~clk;

   key_schedule_ctrl #(.NUM_ROUNDS(12)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .key_clear(key_clear), .busy(busy),
      .rk_ready(rk_ready), .ks_data_in(ks_data_in), .ks_round(ks_round),
      .ks_data_out(ks_data_out), .rk_rd_idx(rk_rd_idx),
`ifdef KEY_SCHED_REVERSE_EN
      .rk_reverse(rk_reverse),
`endif
      .rk_rd_data(rk_rd_data)
   );

   // Stand-in combinational datapath: round 0 passes the key through.
   function automatic logic [127:0] dp(input logic [127:0] din, input logic [3:0] rnd);
      if (rnd == 4'd0) return din;
      return {din[119:0], din[127:120]} ^ {rnd, 124'd0} ^ {96'd0, din[127:96]};
   endfunction

   assign ks_data_out = dp(ks_data_in, ks_round);

   task automatic make_gold(input int k, input logic [127:0] key);
      gold[k][0] = key;
      for (int r = 1; r <= 12; r++) gold[k][r] = dp(gold[k][r-1], 4'(r));
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string name, input logic [3:0] idx, input logic [127:0] exp);
      rk_rd_idx = idx;
      tick();
      check(name, rk_rd_data, exp);
   endtask

   // Accept a key and track it to completion; optionally hold key_valid with another key during RUN.
   task automatic run_key(input logic [127:0] key, input bit hold_other);
      int edges;
      key_in    = key;
      key_valid = 1'b1;
      tick();
      edges = 1;
      check("accept_busy", {127'd0, busy}, 128'd1);
      check("accept_rk_ready", {127'd0, rk_ready}, 128'd0);
      if (hold_other) key_in = KEY_C;
      else key_valid = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         if (n == 12) key_valid = 1'b0;
         tick();
         edges++;
         check($sformatf("round_%0d", n), {124'd0, ks_round}, 128'(n));
         check("run_busy", {127'd0, busy}, 128'd1);
         check("run_key_ready", {127'd0, key_ready}, 128'd0);
      end
      tick();
      edges++;
      check("done_rk_ready", {127'd0, rk_ready}, 128'd1);
      check("done_busy", {127'd0, busy}, 128'd0);
      check("latency", 128'(edges), 128'd14);
   endtask

   initial begin
      int guard;
      rst = 1'b1; key_in = 128'd0; key_valid = 1'b0; key_clear = 1'b0; rk_rd_idx = 4'd0;
`ifdef KEY_SCHED_REVERSE_EN
      rk_reverse = 1'b0;
`endif
      make_gold(0, KEY_A);
      make_gold(1, KEY_B);
      make_gold(2, KEY_C);
      for (int i = 0; i <= 12; i++) tbl[i] = '{idx: 4'(i), exp: gold[0][i]};
      tbl[13] = '{idx: 4'd13, exp: 128'd0};
      tbl[14] = '{idx: 4'd15, exp: 128'd0};

      #2;
      check("rst_key_ready", {127'd0, key_ready}, 128'd1);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_rk_ready", {127'd0, rk_ready}, 128'd0);
      check("rst_rd_data", rk_rd_data, 128'd0);
      check("rst_w", ks_data_in, 128'd0);
      @(negedge clk) rst = 1'b0;

      // Asynchronous reset in the middle of a schedule.
      key_in = KEY_A; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      guard = 0;
      while (ks_round != 4'd5 && guard < 20) begin tick(); guard++; end
      check("reach_r5", {124'd0, ks_round}, 128'd5);
      #2 rst = 1'b1;
      #1;
      check("arst_key_ready", {127'd0, key_ready}, 128'd1);
      check("arst_busy", {127'd0, busy}, 128'd0);
      check("arst_rk_ready", {127'd0, rk_ready}, 128'd0);
      check("arst_round", {124'd0, ks_round}, 128'd0);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i <= 12; i++) rd($sformatf("arst_rd_%0d", i), 4'(i), 128'd0);

      // Full schedule of key A while a different key is held valid during RUN.
      run_key(KEY_A, 1'b1);
      for (int i = 0; i < 15; i++) rd($sformatf("rd_a_idx%0d", tbl[i].idx), tbl[i].idx, tbl[i].exp);

      // Reload from DONE with key B.
      key_in = KEY_B; key_valid = 1'b1;
      tick();
      check("reload_rk_drop", {127'd0, rk_ready}, 128'd0);
      key_valid = 1'b0;
      for (int n = 1; n <= 12; n++) tick();
      check("reload_not_yet", {127'd0, rk_ready}, 128'd0);
      tick();
      check("reload_rk_ready", {127'd0, rk_ready}, 128'd1);
      rd("rd_b_0", 4'd0, gold[1][0]);
      rd("rd_b_7", 4'd7, gold[1][7]);
      rd("rd_b_12", 4'd12, gold[1][12]);

`ifdef KEY_SCHED_REVERSE_EN
      rk_reverse = 1'b1;
      rd("rev_0", 4'd0, gold[1][12]);
      rd("rev_12", 4'd12, gold[1][0]);
      rd("rev_14", 4'd14, 128'd0);
      rk_reverse = 1'b0;
`endif

      // Clear from DONE, then clear+valid together in IDLE.
      key_clear = 1'b1;
      tick();
      check("clr_rk_ready", {127'd0, rk_ready}, 128'd0);
      check("clr_key_ready", {127'd0, key_ready}, 128'd1);
      key_in = KEY_C; key_valid = 1'b1;
      tick();
      key_clear = 1'b0; key_valid = 1'b0;
      check("clrv_busy", {127'd0, busy}, 128'd0);
      check("clrv_w", ks_data_in, 128'd0);
      tick();
      check("clrv_still_idle", {127'd0, busy}, 128'd0);
      rd("clr_retained_7", 4'd7, gold[1][7]);

      // Mid-RUN clear at round 6.
      key_in = KEY_C; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      guard = 0;
      while (ks_round != 4'd6 && guard < 20) begin tick(); guard++; end
      check("reach_r6", {124'd0, ks_round}, 128'd6);
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
      check("mclr_busy", {127'd0, busy}, 128'd0);
      check("mclr_rk_ready", {127'd0, rk_ready}, 128'd0);
      check("mclr_round", {124'd0, ks_round}, 128'd0);
      check("mclr_key_ready", {127'd0, key_ready}, 128'd1);
      rd("mclr_rd_3", 4'd3, gold[2][3]);
      rd("mclr_rd_9", 4'd9, gold[1][9]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
